core_scheduler: RTL and testbench

CORE_SCHEDULER -- requirements
Module: core_scheduler

---
 rtl/core_scheduler.sv | 184 ++++++++++++++++++
 tb/tb_core_scheduler.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/core_scheduler.sv
// Instruction-sequencing FSM: FETCH/DECODE/REQUEST/WAIT/EXECUTE/UPDATE with registered Moore strobes.
// Optional wait-state watchdog is built only when SCHED_TIMEOUT_EN is defined.
module core_scheduler #(
  parameter int         PC_W       = 8,
  parameter logic [2:0] HALT_OP    = 3'b111,
  parameter int         TMO_CYCLES = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            fetch_valid,
  input  logic [2:0]      opcode,
  input  logic            mem_read,
  input  logic            mem_write,
  input  logic            lsu_done,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] branch_target,
  output logic            fetch_start,
  output logic            lsu_req,
  output logic            alu_enable,
  output logic            reg_write_en,
  output logic [PC_W-1:0] pc,
  output logic [2:0]      state,
  output logic            done,
  output logic            busy,
  output logic            error
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_REQUEST = 3'd3,
    S_WAIT    = 3'd4,
    S_EXECUTE = 3'd5,
    S_UPDATE  = 3'd6,
    S_DONE    = 3'd7
  } state_e;

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            fetch_start_q, fetch_start_d;
  logic            lsu_req_q, lsu_req_d;
  logic            alu_enable_q, alu_enable_d;
  logic            reg_write_en_q, reg_write_en_d;
  logic            done_q, done_d;
  logic            busy_q, busy_d;
  logic            launch;
  logic            wd_fire;

  assign launch = start && (state_q == S_IDLE || state_q == S_DONE);

`ifdef SCHED_TIMEOUT_EN
  localparam int CNT_W = $clog2(TMO_CYCLES + 1);

  logic [CNT_W-1:0] wd_cnt_q, wd_cnt_d;
  logic             error_q, error_d;

  // Fires on the last allowed cycle of FETCH/WAIT if the handshake is still missing.
  assign wd_fire = (wd_cnt_q == CNT_W'(TMO_CYCLES - 1)) &&
                   ((state_q == S_FETCH && !fetch_valid) ||
                    (state_q == S_WAIT  && !lsu_done));

  always_comb begin
    wd_cnt_d = wd_cnt_q;
    if (state_d != state_q) begin
      wd_cnt_d = '0;
    end else if (state_q == S_FETCH || state_q == S_WAIT) begin
      wd_cnt_d = wd_cnt_q + 1'b1;
    end
  end

  always_comb begin
    error_d = error_q;
    if (launch) begin
      error_d = 1'b0;
    end else if (wd_fire) begin
      error_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wd_cnt_q <= '0;
      error_q  <= 1'b0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
      error_q  <= error_d;
    end
  end

  assign error = error_q;
`else
  assign wd_fire = 1'b0;
  // No watchdog in this build; the limit only keeps the parameter referenced.
  assign error   = 1'b0 && (TMO_CYCLES > 0);
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_FETCH;
          pc_d    = '0;
        end
      end
      S_FETCH: begin
        if (fetch_valid) begin
          state_d = S_DECODE;
        end else if (wd_fire) begin
          state_d = S_DONE;
        end
      end
      S_DECODE: begin
        state_d = (opcode == HALT_OP) ? S_DONE : S_REQUEST;
      end
      S_REQUEST: begin
        state_d = (mem_read || mem_write) ? S_WAIT : S_EXECUTE;
      end
      S_WAIT: begin
        if (lsu_done) begin
          state_d = S_EXECUTE;
        end else if (wd_fire) begin
          state_d = S_DONE;
        end
      end
      S_EXECUTE: begin
        state_d = S_UPDATE;
      end
      S_UPDATE: begin
        state_d = S_FETCH;
        pc_d    = branch_taken ? branch_target : pc_q + 1'b1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Strobes are decoded from the next state so they are registered yet aligned with state.
  always_comb begin
    fetch_start_d  = (state_d == S_FETCH);
    lsu_req_d      = (state_d == S_WAIT) ||
                     (state_d == S_REQUEST && (mem_read || mem_write));
    alu_enable_d   = (state_d == S_EXECUTE);
    reg_write_en_d = (state_d == S_UPDATE) && !mem_write;
    done_d         = (state_d == S_DONE);
    busy_d         = (state_d != S_IDLE) && (state_d != S_DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      pc_q           <= '0;
      fetch_start_q  <= 1'b0;
      lsu_req_q      <= 1'b0;
      alu_enable_q   <= 1'b0;
      reg_write_en_q <= 1'b0;
      done_q         <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      fetch_start_q  <= fetch_start_d;
      lsu_req_q      <= lsu_req_d;
      alu_enable_q   <= alu_enable_d;
      reg_write_en_q <= reg_write_en_d;
      done_q         <= done_d;
      busy_q         <= busy_d;
    end
  end

  assign state        = state_q;
  assign pc           = pc_q;
  assign fetch_start  = fetch_start_q;
  assign lsu_req      = lsu_req_q;
  assign alu_enable   = alu_enable_q;
  assign reg_write_en = reg_write_en_q;
  assign done         = done_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_core_scheduler.sv
// Directed bench for core_scheduler: each task drives one scenario and checks inline.
module tb_core_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       fetch_valid;
  logic [2:0] opcode;
  logic       mem_read;
  logic       mem_write;
  logic       lsu_done;
  logic       branch_taken;
  logic [7:0] branch_target;
  logic       fetch_start;
  logic       lsu_req;
  logic       alu_enable;
  logic       reg_write_en;
  logic [7:0] pc;
  logic [2:0] state;
  logic       done;
  logic       busy;
  logic       error;

  int vec  = 0;
  int miss = 0;

  core_scheduler dut (
    .clk(clk), .reset(reset), .start(start), .fetch_valid(fetch_valid),
    .opcode(opcode), .mem_read(mem_read), .mem_write(mem_write),
    .lsu_done(lsu_done), .branch_taken(branch_taken), .branch_target(branch_target),
    .fetch_start(fetch_start), .lsu_req(lsu_req), .alu_enable(alu_enable),
    .reg_write_en(reg_write_en), .pc(pc), .state(state), .done(done),
    .busy(busy), .error(error)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_prog();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Runs one instruction from FETCH until the next FETCH (or DONE), tallying strobe cycles.
  task automatic run_instr(input logic [2:0] op, input logic mr, input logic mw,
                           input logic bt, input logic [7:0] tgt, input int done_after,
                           output int cyc, output int n_lsu, output int n_alu,
                           output int n_rwe, output int n_wait, output bit exec_ok);
    bit prev_done;
    opcode = op; mem_read = mr; mem_write = mw;
    branch_taken = bt; branch_target = tgt; fetch_valid = 1'b1; lsu_done = 1'b0;
    cyc = 0; n_lsu = 0; n_alu = 0; n_rwe = 0; n_wait = 0; exec_ok = 1'b1;
    for (int k = 0; k < 60; k++) begin
      if (lsu_req) n_lsu++;
      if (alu_enable) n_alu++;
      if (reg_write_en) n_rwe++;
      if (state == 3'd4) begin
        n_wait++;
        lsu_done = (n_wait == done_after);
      end else begin
        lsu_done = 1'b0;
      end
      prev_done = lsu_done;
      step();
      cyc++;
      if (prev_done && state != 3'd5) exec_ok = 1'b0;
      if (state == 3'd1 || state == 3'd7) break;
    end
    lsu_done = 1'b0;
    branch_taken = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; fetch_valid = 1'b0; opcode = 3'd0;
    mem_read = 1'b0; mem_write = 1'b0; lsu_done = 1'b0;
    branch_taken = 1'b0; branch_target = 8'h00;
    #2;
    vec++; if (state !== 3'd0) begin miss++; $display("FAIL reset_state: got %0d expected 0", state); end
    vec++; if (pc !== 8'h00) begin miss++; $display("FAIL reset_pc: got %0h expected 0", pc); end
    vec++; if ({done, busy, error} !== 3'b000) begin miss++; $display("FAIL reset_flags: got %b expected 000", {done, busy, error}); end
    vec++; if ({fetch_start, lsu_req, alu_enable, reg_write_en} !== 4'b0000) begin
      miss++; $display("FAIL reset_strobes: got %b expected 0000", {fetch_start, lsu_req, alu_enable, reg_write_en}); end
    start = 1'b1;
    step(); step();
    vec++; if (state !== 3'd0) begin miss++; $display("FAIL start_in_reset: got %0d expected 0", state); end
    start = 1'b0;
    reset = 1'b1;
    step(); step(); step();
    vec++; if (state !== 3'd0 || busy !== 1'b0) begin
      miss++; $display("FAIL idle_after_reset: got state %0d busy %b expected 0 0", state, busy); end
  endtask

  task automatic test_alu_halt();
    logic [2:0] exp_seq [8] = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd6, 3'd1, 3'd2, 3'd7};
    int n_rwe = 0;
    fetch_valid = 1'b1; opcode = 3'b001; mem_read = 1'b0; mem_write = 1'b0;
    start_prog();
    for (int i = 0; i < 8; i++) begin
      vec++; if (state !== exp_seq[i]) begin
        miss++; $display("FAIL alu_seq[%0d]: got %0d expected %0d", i, state, exp_seq[i]); end
      if (reg_write_en) n_rwe++;
      if (state == 3'd6) opcode = 3'b111;
      if (i < 7) step();
    end
    vec++; if (n_rwe != 1) begin miss++; $display("FAIL alu_rwe_pulses: got %0d expected 1", n_rwe); end
    vec++; if (pc !== 8'h01) begin miss++; $display("FAIL alu_pc: got %0h expected 1", pc); end
    vec++; if (done !== 1'b1 || busy !== 1'b0) begin
      miss++; $display("FAIL alu_done: got done %b busy %b expected 1 0", done, busy); end
  endtask

  task automatic test_load();
    int cyc, n_lsu, n_alu, n_rwe, n_wait;
    bit exec_ok;
    start_prog();
    vec++; if (state !== 3'd1 || pc !== 8'h00) begin
      miss++; $display("FAIL restart_from_done: got state %0d pc %0h expected 1 0", state, pc); end
    run_instr(3'b001, 1'b1, 1'b0, 1'b0, 8'h00, 3, cyc, n_lsu, n_alu, n_rwe, n_wait, exec_ok);
    vec++; if (n_lsu != 4) begin miss++; $display("FAIL load_lsu_cycles: got %0d expected 4", n_lsu); end
    vec++; if (n_wait != 3) begin miss++; $display("FAIL load_wait_cycles: got %0d expected 3", n_wait); end
    vec++; if (!exec_ok) begin miss++; $display("FAIL load_exec_after_done: got 0 expected 1"); end
    vec++; if (n_rwe != 1 || n_alu != 1) begin
      miss++; $display("FAIL load_pulses: got rwe %0d alu %0d expected 1 1", n_rwe, n_alu); end
    vec++; if (cyc != 8) begin miss++; $display("FAIL load_latency: got %0d expected 8", cyc); end
    vec++; if (pc !== 8'h01) begin miss++; $display("FAIL load_pc: got %0h expected 1", pc); end
    run_instr(3'b111, 1'b0, 1'b0, 1'b0, 8'h00, 0, cyc, n_lsu, n_alu, n_rwe, n_wait, exec_ok);
    vec++; if (state !== 3'd7 || done !== 1'b1) begin
      miss++; $display("FAIL load_halt: got state %0d done %b expected 7 1", state, done); end
  endtask

  task automatic test_store();
    int cyc, n_lsu, n_alu, n_rwe, n_wait;
    bit exec_ok;
    fetch_valid = 1'b0;
    start_prog();
    step(); step(); step();
    vec++; if (state !== 3'd1 || fetch_start !== 1'b1) begin
      miss++; $display("FAIL fetch_stall: got state %0d fetch_start %b expected 1 1", state, fetch_start); end
    run_instr(3'b010, 1'b0, 1'b1, 1'b0, 8'h00, 1, cyc, n_lsu, n_alu, n_rwe, n_wait, exec_ok);
    vec++; if (n_lsu != 2) begin miss++; $display("FAIL store_lsu_cycles: got %0d expected 2", n_lsu); end
    vec++; if (n_alu != 1) begin miss++; $display("FAIL store_alu: got %0d expected 1", n_alu); end
    vec++; if (n_rwe != 0) begin miss++; $display("FAIL store_no_rwe: got %0d expected 0", n_rwe); end
    vec++; if (pc !== 8'h01) begin miss++; $display("FAIL store_pc: got %0h expected 1", pc); end
    mem_write = 1'b0;
  endtask

  task automatic test_branch();
    int cyc, n_lsu, n_alu, n_rwe, n_wait;
    bit exec_ok;
    run_instr(3'b001, 1'b0, 1'b0, 1'b1, 8'h40, 0, cyc, n_lsu, n_alu, n_rwe, n_wait, exec_ok);
    vec++; if (pc !== 8'h40 || fetch_start !== 1'b1) begin
      miss++; $display("FAIL branch_pc: got pc %0h fetch_start %b expected 40 1", pc, fetch_start); end
    vec++; if (cyc != 5) begin miss++; $display("FAIL min_latency: got %0d expected 5", cyc); end
    start = 1'b1;
    run_instr(3'b001, 1'b0, 1'b0, 1'b0, 8'h00, 0, cyc, n_lsu, n_alu, n_rwe, n_wait, exec_ok);
    start = 1'b0;
    vec++; if (pc !== 8'h41) begin miss++; $display("FAIL start_ignored_busy: got pc %0h expected 41", pc); end
    run_instr(3'b001, 1'b0, 1'b0, 1'b1, 8'hFF, 0, cyc, n_lsu, n_alu, n_rwe, n_wait, exec_ok);
    vec++; if (pc !== 8'hFF) begin miss++; $display("FAIL branch_ff: got pc %0h expected ff", pc); end
    run_instr(3'b001, 1'b0, 1'b0, 1'b0, 8'h00, 0, cyc, n_lsu, n_alu, n_rwe, n_wait, exec_ok);
    vec++; if (pc !== 8'h00) begin miss++; $display("FAIL pc_wrap: got pc %0h expected 0", pc); end
  endtask

  task automatic test_reset_midwait();
    int cyc, n_lsu, n_alu, n_rwe, n_wait;
    bit exec_ok;
    int n_resp = 0;
    run_instr(3'b001, 1'b0, 1'b0, 1'b1, 8'h22, 0, cyc, n_lsu, n_alu, n_rwe, n_wait, exec_ok);
    opcode = 3'b001; mem_read = 1'b1; fetch_valid = 1'b1;
    for (int k = 0; k < 10 && state != 3'd4; k++) step();
    vec++; if (state !== 3'd4 || lsu_req !== 1'b1 || pc !== 8'h22) begin
      miss++; $display("FAIL reach_wait: got state %0d lsu_req %b pc %0h expected 4 1 22", state, lsu_req, pc); end
    #2;
    reset = 1'b0;
    #1;
    vec++; if (state !== 3'd0 || pc !== 8'h00 || busy !== 1'b0) begin
      miss++; $display("FAIL async_reset: got state %0d pc %0h busy %b expected 0 0 0", state, pc, busy); end
    vec++; if ({fetch_start, lsu_req, alu_enable, reg_write_en} !== 4'b0000) begin
      miss++; $display("FAIL async_reset_strobes: got %b expected 0000", {fetch_start, lsu_req, alu_enable, reg_write_en}); end
    #1;
    reset = 1'b1;
    lsu_done = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      if (lsu_req || reg_write_en || alu_enable || state != 3'd0) n_resp++;
    end
    lsu_done = 1'b0; mem_read = 1'b0;
    vec++; if (n_resp != 0) begin miss++; $display("FAIL post_reset_response: got %0d cycles expected 0", n_resp); end
  endtask

  task automatic test_watchdog();
    int n_wait = 0;
    int n_rwe  = 0;
    opcode = 3'b001; mem_read = 1'b1; fetch_valid = 1'b1; lsu_done = 1'b0;
    start_prog();
    for (int k = 0; k < 200; k++) begin
      if (state == 3'd7) break;
`ifndef SCHED_TIMEOUT_EN
      if (n_wait == 100) break;
`endif
      if (state == 3'd4) n_wait++;
      if (reg_write_en) n_rwe++;
      step();
    end
`ifdef SCHED_TIMEOUT_EN
    vec++; if (n_wait != 64) begin miss++; $display("FAIL wd_wait_cycles: got %0d expected 64", n_wait); end
    vec++; if (state !== 3'd7 || error !== 1'b1 || n_rwe != 0) begin
      miss++; $display("FAIL wd_fire: got state %0d error %b rwe %0d expected 7 1 0", state, error, n_rwe); end
    mem_read = 1'b0;
    start_prog();
    vec++; if (error !== 1'b0 || state !== 3'd1) begin
      miss++; $display("FAIL wd_clear: got error %b state %0d expected 0 1", error, state); end
`else
    vec++; if (state !== 3'd4 || error !== 1'b0 || n_wait != 100) begin
      miss++; $display("FAIL wait_forever: got state %0d error %b waits %0d expected 4 0 100", state, error, n_wait); end
    lsu_done = 1'b1;
    step();
    lsu_done = 1'b0;
    vec++; if (state !== 3'd5 || alu_enable !== 1'b1) begin
      miss++; $display("FAIL late_done_exec: got state %0d alu %b expected 5 1", state, alu_enable); end
    mem_read = 1'b0;
`endif
  endtask

  initial begin
    test_reset();
    test_alu_halt();
    test_load();
    test_store();
    test_branch();
    test_reset_midwait();
    test_watchdog();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
